// File: rtl/fcvt_pkg.sv
// Shared definitions for the int-to-float conversion scheduler.
// Holds parameter defaults, the requester source encoding and small helpers.
package fcvt_pkg;

  localparam int TAG_W_DEF = 5;
  localparam int DEPTH_DEF = 4;

  typedef enum logic {
    SRC_INT = 1'b0,
    SRC_FPU = 1'b1
  } src_e;

  // Round-robin pick between two requesters; last is the previous winner.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] valid,
    input logic       last
  );
    logic [1:0] g;
    g = '0;
    unique case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/fcvt_res_fifo.sv
// Result queue for converted values.
// Circular buffer with occupancy count and a synchronous clear.
module fcvt_res_fifo #(
  parameter  int W     = 38,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  // Storage array; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointers and occupancy; clear drops everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fcvt_sched.sv
// Arbiter for a shared int-to-float converter between two pipes.
// Tracks the single in-flight op and queues results in accept order.
module fcvt_sched
  import fcvt_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            rq_valid,
  output logic [1:0]            rq_ready,
  input  logic [1:0][31:0]      rq_a,
  input  logic [1:0][TAG_W-1:0] rq_tag,
  output logic [31:0]           cv_a,
  output logic                  cv_en,
  input  logic [31:0]           cv_res,
  input  logic                  cv_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_res,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_src,
  input  logic                  flush,
  output logic                  err
);

  localparam int EW = 32 + TAG_W + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]       gnt;
  logic             sel;
  logic             any;
  logic             inflight_q;
  logic             kill_q;
  logic             guard_q;
  logic             rr_q;
  logic             err_q;
  logic [TAG_W-1:0] tag_q;
  src_e             src_q;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic [CW:0]      used;
  logic             space_ok;
  logic             push_try;
  logic             push;
  logic             pop;
  logic             viol;
  logic             ovf;
  logic [EW-1:0]    din;
  logic [EW-1:0]    dout;

  // Slots already spoken for: queued results plus the op in the converter.
  assign used     = {1'b0, count} + (CW+1)'(inflight_q);
  assign space_ok = used < (CW+1)'(DEPTH);

  // Grant at most one requester when a result slot is guaranteed.
  always_comb begin
    gnt = '0;
    if (!rst && !flush && space_ok) gnt = rr_pick(rq_valid, rr_q);
  end

  assign any      = |gnt;
  assign sel      = gnt[1];
  assign rq_ready = gnt;
  assign cv_en    = any;
  assign cv_a     = any ? rq_a[sel] : '0;

  // A result is queued only for a live op; stray or late results are errors.
  assign push_try = cv_ready & inflight_q & ~kill_q & ~flush;
  assign viol     = cv_ready & ~inflight_q & ~guard_q;
  assign ovf      = push_try & full;
  assign push     = push_try & ~full;
  assign pop      = out_valid & out_ready;
  assign din      = {cv_res, tag_q, logic'(src_q)};

  // In-flight tracking: tag/src of the op whose result arrives next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      tag_q      <= '0;
      src_q      <= SRC_INT;
    end else if (any) begin
      inflight_q <= 1'b1;
      kill_q     <= 1'b0;
      tag_q      <= rq_tag[sel];
      src_q      <= sel ? SRC_FPU : SRC_INT;
    end else if (cv_ready) begin
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else if (flush && inflight_q) begin
      kill_q     <= 1'b1;
    end
  end

  // Round-robin pointer, sticky error and post-reset guard window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= 1'b1;
      err_q   <= 1'b0;
      guard_q <= 1'b1;
    end else begin
      if (any) rr_q <= sel;
      if (viol || ovf) err_q <= 1'b1;
      guard_q <= 1'b0;
    end
  end

  fcvt_res_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_valid = ~empty;
  assign err       = err_q;
  assign {out_res, out_tag, out_src} = out_valid ? dout : '0;

endmodule

// File: tb/tb_fcvt_sched.sv
// Scoreboard bench for fcvt_sched with a converter model and random traffic.
// Expected grants and results come from a queue-based reference model.
module tb_fcvt_sched;
  import fcvt_pkg::*;

  localparam int TAG_W = TAG_W_DEF;
  localparam int DEPTH = DEPTH_DEF;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            rq_valid;
  logic [1:0]            rq_ready;
  logic [1:0][31:0]      rq_a;
  logic [1:0][TAG_W-1:0] rq_tag;
  logic [31:0]           cv_a;
  logic                  cv_en;
  logic [31:0]           cv_res;
  logic                  cv_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_res;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_src;
  logic                  flush;
  logic                  err;

  always #5 clk = ~clk;

  fcvt_sched #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rq_valid  (rq_valid),
    .rq_ready  (rq_ready),
    .rq_a      (rq_a),
    .rq_tag    (rq_tag),
    .cv_a      (cv_a),
    .cv_en     (cv_en),
    .cv_res    (cv_res),
    .cv_ready  (cv_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_src   (out_src),
    .flush     (flush),
    .err       (err)
  );

  // Unsigned integer to single precision, truncating extra mantissa bits.
  function automatic logic [31:0] i2f(input logic [31:0] x);
    int          e;
    logic [31:0] sh;
    if (x == 32'h0) return 32'h0;
    e = 31;
    while (!x[e]) e--;
    sh = x << (31 - e);
    return {1'b0, 8'(127 + e), sh[30:8]};
  endfunction

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             src;
    int               cyc;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        m_last = 1'b1;
  logic        m_gnt_prev = 1'b0;
  logic        exp_err = 1'b0;
  logic        prev_rst = 1'b1;
  logic [1:0]  acc = 2'b00;
  logic [1:0]  m_eg;
  logic        m_mv;
  logic        m_s;
  logic        spur = 1'b0;
  logic        sp_cap = 1'b0;
  logic        en_cap = 1'b0;
  logic [31:0] a_cap = 32'h0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Converter model: answers one cycle after cv_en; spur injects a stray result.
  initial begin
    cv_ready = 1'b0;
    cv_res   = 32'h0;
    forever begin
      @(negedge clk);
      en_cap = cv_en;
      a_cap  = cv_a;
      sp_cap = spur;
      spur   = 1'b0;
      @(posedge clk);
      #1;
      cv_ready = en_cap | sp_cap;
      cv_res   = en_cap ? i2f(a_cap) : (sp_cap ? 32'hDEADBEEF : 32'h0);
    end
  end

  // Monitor and reference model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        m_last     = 1'b1;
        m_gnt_prev = 1'b0;
        exp_err    = 1'b0;
        prev_rst   = 1'b1;
        acc        = 2'b00;
        chk("rst_rq_ready", rq_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cv_en", cv_en, 0);
        chk("rst_err", err, 0);
      end else begin
        chk("err", err, exp_err);
        if (cv_ready && !m_gnt_prev && !prev_rst) exp_err = 1'b1;
        m_eg = 2'b00;
        if (!flush && q.size() < DEPTH) begin
          if (rq_valid == 2'b11) m_eg = m_last ? 2'b01 : 2'b10;
          else m_eg = rq_valid;
        end
        chk("rq_ready", rq_ready, m_eg);
        chk("cv_en", cv_en, |m_eg);
        chk("cv_a", cv_a, m_eg[1] ? rq_a[1] : (m_eg[0] ? rq_a[0] : 32'h0));
        m_mv = (q.size() > 0) && (q[0].cyc <= cyc - 2);
        chk("out_valid", out_valid, m_mv);
        if (m_mv && out_ready) begin
          chk("out_res", out_res, q[0].res);
          chk("out_tag", out_tag, q[0].tag);
          chk("out_src", out_src, q[0].src);
          void'(q.pop_front());
        end else if (!out_valid) begin
          chk("out_idle", {out_res, out_tag, out_src}, 0);
        end
        if (flush) q.delete();
        if (|m_eg) begin
          m_s = m_eg[1];
          q.push_back('{res: i2f(rq_a[m_s]), tag: rq_tag[m_s],
                        src: m_s, cyc: cyc});
          m_last = m_s;
        end
        m_gnt_prev = |m_eg;
        prev_rst   = 1'b0;
        acc        = rq_ready & rq_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (acc[i]) rq_valid[i] = 1'b0;
  endtask

  task automatic req(input int i, input logic [31:0] a, input logic [31:0] t);
    rq_valid[i] = 1'b1;
    rq_a[i]     = a;
    rq_tag[i]   = t[TAG_W-1:0];
  endtask

  int n_acc;

  // Directed scenarios followed by random traffic.
  initial begin
    rst       = 1'b1;
    rq_valid  = '0;
    rq_a      = '0;
    rq_tag    = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Tie after reset: both valid continuously.
    for (int k = 0; k < 8; k++) begin
      if (!rq_valid[0]) req(0, $urandom, 1);
      if (!rq_valid[1]) req(1, $urandom, 2);
      tick();
    end
    for (int k = 0; k < 6 && rq_valid != 2'b00; k++) tick();
    repeat (4) tick();

    // Single op with known result.
    req(0, 32'h1, 3);
    repeat (5) tick();

    // Backpressure: FIFO plus in-flight caps acceptance.
    out_ready = 1'b0;
    n_acc = 0;
    req(0, 32'd100, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      n_acc += int'(acc[0]);
      if (!rq_valid[0]) req(0, 32'd101 + k, k);
    end
    chk("bp_accepts", n_acc, DEPTH);
    out_ready = 1'b1;
    repeat (10) tick();

    // Flush right after an accept.
    req(0, 32'h1234, 7);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();

    // Random traffic with backpressure and occasional flush.
    for (int k = 0; k < 1500; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      for (int i = 0; i < 2; i++)
        if (!rq_valid[i] && $urandom_range(0, 2) == 0)
          req(i, $urandom, $urandom);
      tick();
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && rq_valid != 2'b00; k++) tick();
    for (int k = 0; k < 50 && q.size() > 0; k++) tick();
    chk("drain_empty", q.size(), 0);
    repeat (2) tick();

    // Stray converter result with nothing in flight.
    spur = 1'b1;
    repeat (4) tick();
    chk("err_sticky", err, 1);

    // Reset with two queued and one in flight.
    out_ready = 1'b0;
    n_acc = 0;
    req(0, 32'd7, 4);
    for (int k = 0; k < 20 && n_acc < 3; k++) begin
      tick();
      n_acc += int'(acc[0]);
      if (n_acc < 3 && !rq_valid[0]) req(0, 32'd8 + k, 5);
    end
    chk("pre_rst_accepts", n_acc, 3);
    req(0, 32'd55, 9);
    req(1, 32'd66, 10);
    rst  = 1'b1;
    spur = 1'b1;
    #1;
    chk("rst_now_rq_ready", rq_ready, 0);
    chk("rst_now_out_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("post_rst_err", err, 0);
    for (int k = 0; k < 50 && q.size() > 0; k++) tick();
    chk("final_drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
